// File: rtl/speed_logger_pkg.sv
// Shared definitions for the toll-lane speed path: default widths, clock rate,
// speed limit, record/bus field positions and the LED FSM state encoding.
package speed_logger_pkg;

    localparam int DEF_WIDTH_SPEED = 14;
    localparam int DEF_WIDTH_CNT   = 16;
    localparam int DEF_DEPTH       = 8;
    localparam int SYS_FREQ        = 10_000_000;
    localparam int DEF_SPEED_LIMIT = 60;
    localparam int DEF_LED_HOLD    = SYS_FREQ / 2;

    localparam int REC_SPEED_LSB = 0;
    localparam int REC_OVS_IDX   = DEF_WIDTH_SPEED;
    localparam int BUS_DONE_IDX  = DEF_WIDTH_SPEED;

    // The flag bit sits directly above the speed field in both the bus and the record.
    function automatic int flag_idx(input int width_speed);
        return width_speed;
    endfunction

    typedef enum logic {
        LED_ST_IDLE = 1'b0,
        LED_ST_HOLD = 1'b1
    } led_state_e;

endpackage

// File: rtl/speed_logger_if.sv
// Valid/ready read port carrying {overspeed, speed} records to the display/UART stage.
interface speed_logger_if #(
    parameter int WIDTH = 15
) ();
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/speed_logger_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered head output that
// accepts a push into a full FIFO when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] PTR_ZERO = {(AW + 1){1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Next pointers and next head record, looking through a same-cycle write.
    always_comb begin
        full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop_s   = pop & rd_valid_q;
        do_push_s  = push & (~full_s | do_pop_s);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (clear) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            rd_valid_d = 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            rd_valid_d = (wr_ptr_d != rd_ptr_d);
            // Empty-before-push means the new head is the word being written now.
            if (!rd_valid_d) begin
                rd_data_d = rd_data_q;
            end else if (do_push_s && (rd_ptr_d == wr_ptr_q)) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!reset && !clear && do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and head-register state.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign full     = full_s;

endmodule

// File: rtl/speed_logger.sv
// Captures one {overspeed, speed} record per rising edge of done, queues it for
// the display stage, counts vehicles/violations and stretches an overspeed LED.
module speed_logger
    import speed_logger_pkg::*;
#(
    parameter int WIDTH_SPEED = DEF_WIDTH_SPEED,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SPEED_LIMIT = DEF_SPEED_LIMIT,
    parameter int WIDTH_CNT   = DEF_WIDTH_CNT,
    parameter int LED_HOLD    = DEF_LED_HOLD
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH_SPEED:0]   done_speed,
    input  logic                   clear,
    speed_logger_if.master         rd,
    output logic [WIDTH_CNT-1:0]   veh_count,
    output logic [WIDTH_CNT-1:0]   viol_count,
    output logic                   overflow,
    output logic                   led_overspeed
);

    localparam int FLAG_IDX = flag_idx(WIDTH_SPEED);
    localparam logic [31:0]          LIMIT_W  = 32'(SPEED_LIMIT);
    localparam logic [WIDTH_CNT-1:0] CNT_ONE  = {{(WIDTH_CNT - 1){1'b0}}, 1'b1};
    localparam logic [WIDTH_CNT-1:0] CNT_MAX  = {WIDTH_CNT{1'b1}};
    localparam logic [WIDTH_CNT-1:0] CNT_ZERO = {WIDTH_CNT{1'b0}};
    localparam int TW = (LED_HOLD > 1) ? $clog2(LED_HOLD) : 1;
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LED_HOLD - 1);
    localparam logic [TW-1:0] TIMER_ONE  = {{(TW - 1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};

    logic                   done_prev_q, done_prev_d;
    logic [WIDTH_CNT-1:0]   veh_q, veh_d;
    logic [WIDTH_CNT-1:0]   viol_q, viol_d;
    logic                   overflow_q, overflow_d;
    led_state_e             led_state_q;
    logic [TW-1:0]          led_timer_q;
    logic                   led_q;

    logic                   done_s;
    logic [WIDTH_SPEED-1:0] speed_s;
    logic                   capture_s;
    logic                   ovs_s;
    logic [WIDTH_SPEED:0]   record_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   led_trig_s;

    // Edge detect, classification and record assembly.
    always_comb begin
        done_s      = done_speed[FLAG_IDX];
        speed_s     = done_speed[WIDTH_SPEED-1:0];
        done_prev_d = done_s;
        capture_s   = done_s & ~done_prev_q;
        ovs_s       = (32'(speed_s) > LIMIT_W);
        record_s    = {ovs_s, speed_s};
        pop_s       = rd.rd_valid & rd.rd_ready;
        led_trig_s  = capture_s & ovs_s & ~clear;
    end

    // Saturating counters and sticky overflow; clear overrides any capture.
    always_comb begin
        veh_d      = veh_q;
        viol_d     = viol_q;
        overflow_d = overflow_q;
        if (clear) begin
            veh_d      = CNT_ZERO;
            viol_d     = CNT_ZERO;
            overflow_d = 1'b0;
        end else if (capture_s) begin
            if (veh_q != CNT_MAX) begin
                veh_d = veh_q + CNT_ONE;
            end else begin
                veh_d = veh_q;
            end
            if (ovs_s && (viol_q != CNT_MAX)) begin
                viol_d = viol_q + CNT_ONE;
            end else begin
                viol_d = viol_q;
            end
            if (fifo_full_s && !pop_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
        end else begin
            veh_d      = veh_q;
            viol_d     = viol_q;
            overflow_d = overflow_q;
        end
    end

    // Edge history, counters and overflow flag; history resets high to ignore a held done.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_prev_q <= 1'b1;
            veh_q       <= CNT_ZERO;
            viol_q      <= CNT_ZERO;
            overflow_q  <= 1'b0;
        end else begin
            done_prev_q <= done_prev_d;
            veh_q       <= veh_d;
            viol_q      <= viol_d;
            overflow_q  <= overflow_d;
        end
    end

    // LED stretcher: HOLD lasts LED_HOLD cycles after the most recent overspeed capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_state_q <= LED_ST_IDLE;
            led_timer_q <= TIMER_ZERO;
            led_q       <= 1'b0;
        end else begin
            case (led_state_q)
                LED_ST_IDLE: begin
                    if (led_trig_s) begin
                        led_state_q <= LED_ST_HOLD;
                        led_timer_q <= TIMER_LOAD;
                        led_q       <= 1'b1;
                    end else begin
                        led_q       <= 1'b0;
                    end
                end
                LED_ST_HOLD: begin
                    if (led_trig_s) begin
                        led_timer_q <= TIMER_LOAD;
                        led_q       <= 1'b1;
                    end else if (led_timer_q == TIMER_ZERO) begin
                        led_state_q <= LED_ST_IDLE;
                        led_q       <= 1'b0;
                    end else begin
                        led_timer_q <= led_timer_q - TIMER_ONE;
                        led_q       <= 1'b1;
                    end
                end
                default: begin
                    led_state_q <= LED_ST_IDLE;
                    led_timer_q <= TIMER_ZERO;
                    led_q       <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH_SPEED + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .push     (capture_s),
        .wr_data  (record_s),
        .pop      (pop_s),
        .rd_valid (rd.rd_valid),
        .rd_data  (rd.rd_data),
        .full     (fifo_full_s)
    );

    assign veh_count     = veh_q;
    assign viol_count    = viol_q;
    assign overflow      = overflow_q;
    assign led_overspeed = led_q;

endmodule

// File: tb/tb_speed_logger.sv
// Self-checking bench for speed_logger: vector table for capture/LED timing plus
// hand sequences for overflow, full push+pop, saturation, clear and reset.
module tb_speed_logger;

    localparam int WS    = 14;
    localparam int DEPTH = 8;
    localparam int LIMIT = 60;
    localparam int WC    = 4;
    localparam int HOLD  = 4;
    localparam int CMAX  = (1 << WC) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic [WS:0]   done_speed;
    logic [WC-1:0] veh_count;
    logic [WC-1:0] viol_count;
    logic          overflow;
    logic          led_overspeed;

    speed_logger_if #(.WIDTH(WS + 1)) rd_if ();

    speed_logger #(
        .WIDTH_SPEED (WS),
        .DEPTH       (DEPTH),
        .SPEED_LIMIT (LIMIT),
        .WIDTH_CNT   (WC),
        .LED_HOLD    (HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .done_speed    (done_speed),
        .clear         (clear),
        .rd            (rd_if),
        .veh_count     (veh_count),
        .viol_count    (viol_count),
        .overflow      (overflow),
        .led_overspeed (led_overspeed)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WS:0] exp_q [$];
    bit          m_prev;
    int          m_veh;
    int          m_viol;
    bit          m_ovf;
    int          m_led;

    typedef struct {
        bit done;
        int spd;
        int veh;
        int viol;
        bit led;
        bit valid;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev = 1'b1;
        m_veh  = 0;
        m_viol = 0;
        m_ovf  = 1'b0;
        m_led  = 0;
    endtask

    // Drive one cycle: check current outputs against the model, update the model, clock.
    task automatic step(input bit rst, input bit clr, input bit done, input int spd, input bit rdy);
        bit          cap;
        bit          ovs;
        logic [WS:0] rec;
        reset            = rst;
        clear            = clr;
        done_speed       = {done, WS'(spd)};
        rd_if.rd_ready   = rdy;
        chk("rd_valid", {31'd0, rd_if.rd_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("rd_data", 32'(rd_if.rd_data), 32'(exp_q[0]));
        chk("veh_count", 32'(veh_count), m_veh);
        chk("viol_count", 32'(viol_count), m_viol);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("led", {31'd0, led_overspeed}, {31'd0, m_led > 0});
        if (rst) begin
            model_reset();
        end else begin
            cap    = done && !m_prev;
            m_prev = done;
            ovs    = (spd > LIMIT);
            if (clr) begin
                exp_q.delete();
                m_veh  = 0;
                m_viol = 0;
                m_ovf  = 1'b0;
            end else begin
                if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
                if (cap) begin
                    rec = {ovs, WS'(spd)};
                    if (exp_q.size() < DEPTH) exp_q.push_back(rec);
                    else m_ovf = 1'b1;
                    if (m_veh < CMAX) m_veh++;
                    if (ovs && m_viol < CMAX) m_viol++;
                end
            end
            if (cap && ovs && !clr) m_led = HOLD;
            else if (m_led > 0) m_led--;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 45,  1, 0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 45,  1, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 45,  1, 0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 0,   1, 0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 60,  2, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 60,  2, 0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 61,  3, 1, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 0,   3, 1, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 100, 4, 2, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 0,   4, 2, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 0,   4, 2, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 0,   4, 2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 0,   4, 2, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 0,   4, 2, 1'b0, 1'b0};

        reset          = 1'b1;
        clear          = 1'b0;
        done_speed     = '0;
        rd_if.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_rd_valid", {31'd0, rd_if.rd_valid}, 32'd0);
        chk("rst_rd_data", 32'(rd_if.rd_data), 32'd0);
        chk("rst_veh", 32'(veh_count), 32'd0);
        chk("rst_led", {31'd0, led_overspeed}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);

        // Basic capture, limit boundary and LED stretch/retrigger
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, tbl[i].done, tbl[i].spd, 1'b1);
            chk($sformatf("tbl%0d_veh", i), 32'(veh_count), tbl[i].veh);
            chk($sformatf("tbl%0d_viol", i), 32'(viol_count), tbl[i].viol);
            chk($sformatf("tbl%0d_led", i), {31'd0, led_overspeed}, {31'd0, tbl[i].led});
            chk($sformatf("tbl%0d_valid", i), {31'd0, rd_if.rd_valid}, {31'd0, tbl[i].valid});
        end

        // Fill to full, then capture together with a pop, then a dropped capture
        step(1'b0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b0, 1'b1, i, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        end
        chk("full_ovf", {31'd0, overflow}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 77, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("fpp_ovf", {31'd0, overflow}, 32'd0);
        chk("fpp_veh", 32'(veh_count), 32'd9);
        step(1'b0, 1'b0, 1'b1, 9, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_veh", 32'(veh_count), 32'd10);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        chk("drain_empty", {31'd0, rd_if.rd_valid}, 32'd0);

        // Counter saturation
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, 20 + i, 1'b1);
            step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        end
        chk("sat_veh", 32'(veh_count), CMAX);
        chk("sat_viol", 32'(viol_count), 32'd1);

        // Clear coincident with a done edge while the LED is held
        step(1'b0, 1'b0, 1'b1, 90, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 30, 1'b0);
        chk("clr_led", {31'd0, led_overspeed}, 32'd1);
        chk("clr_veh", 32'(veh_count), 32'd0);
        chk("clr_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_valid", {31'd0, rd_if.rd_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 30, 1'b0);
        chk("clr_lost_edge", 32'(veh_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset with records queued and done held high through release
        for (int i = 11; i <= 13; i++) begin
            step(1'b0, 1'b0, 1'b1, i, 1'b0);
            step(1'b0, 1'b0, 1'b0, 0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1, 95, 1'b0);
        step(1'b1, 1'b0, 1'b1, 50, 1'b0);
        chk("mrst_valid", {31'd0, rd_if.rd_valid}, 32'd0);
        chk("mrst_data", 32'(rd_if.rd_data), 32'd0);
        chk("mrst_veh", 32'(veh_count), 32'd0);
        chk("mrst_led", {31'd0, led_overspeed}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 50, 1'b1);
        chk("held_done_veh", 32'(veh_count), 32'd0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 70, 1'b1);
        chk("post_rst_veh", 32'(veh_count), 32'd1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
